wheel_pulse_meter: RTL and testbench
====================================

# wheel_pulse_meter

Parametrised wheel-pulse front end for the taxi meter: debounces the raw wheel-sensor input and the mode key, runs the trip state machine (IDLE / WAIT / DRIVE), and accumulates pulses, distance units, waiting seconds and windowed speed. It is fully synchronous to sys_clk and sits between the board I/O pins and the fare-calculation and display logic.

## Interface
- CNT_W, 20, width of pulse_num and dist_units
- DEB_MAX, 999_999, debounce length in cycles (≥1; 20 ms at 50 MHz)
- WIN_MAX, 49_999_999, time-window terminal count (1 s at 50 MHz, ≥1)
- PPU, 10, accepted pulses per distance unit (≥1)

Ports:
- sys_clk  in  1  clock
- sys_rst_n  in  1  asynchronous active-low reset
- pulse_port  in  1  raw wheel pulse, active-low, asynchronous
- stat_key  in  1  raw mode key, active-low, asynchronous
- clr  in  1  synchronous trip clear, active-high
- drive_stat  out  2  0=IDLE, 1=WAIT, 2=DRIVE
- pulse_num  out  CNT_W  accepted pulses in DRIVE since clear
- dist_units  out  CNT_W  completed distance units
- wait_sec  out  16  whole windows spent in WAIT
- speed_ppw  out  16  DRIVE pulses counted in last complete window
- pulse_vld  out  1  one-cycle strobe per accepted pulse
- unit_tick  out  1  one-cycle strobe per completed distance unit
- ovf  out  1  sticky: pulse_num or dist_units saturated

## Operation
- Reset is sys_rst_n, asynchronous, active-low; clock is sys_clk. All outputs reset to 0. drive_stat resets to IDLE.
- Debouncer, one instance each for pulse_port and stat_key:
  - The input passes through a 2-flop synchroniser.
  - The counter clears while the synchronised input is high.
  - The counter increments while the synchronised input is low and saturates at DEB_MAX.
  - The strobe fires for exactly one cycle when the counter reaches DEB_MAX.
  - The next strobe needs a release: the synchronised input must go high, then stay low for DEB_MAX cycles again.
- State machine, advanced by the key strobe:
  - IDLE → DRIVE
  - DRIVE → WAIT
  - WAIT → DRIVE
  - drive_stat value 3 is unreachable; if it occurs, the next cycle goes to IDLE.
- Pulse strobe handling in DRIVE:
  - pulse_vld=1.
  - pulse_num increments, saturating at all-ones. A strobe that arrives at saturation sets ovf.
  - The sub-counter counts 0..PPU-1. On wrap it returns to 0, dist_units increments (saturating, sets ovf) and unit_tick=1 in the same cycle.
- Pulse strobes in IDLE or WAIT are dropped: no pulse_vld and no count change.
- Window timer:
  - Free-running 0..WIN_MAX from reset. State and clr do not affect it.
  - Window end is the cycle where the timer equals WIN_MAX.
  - At window end in WAIT, wait_sec increments, saturating at 0xFFFF.
- Simultaneous events:
  - clr has top priority. It sets IDLE and zeroes pulse_num, dist_units, sub-counter, wait_sec and ovf. A same-cycle pulse or key strobe is discarded.
  - Key strobe and pulse strobe in the same cycle: the pulse is evaluated against the pre-transition state.
  - Window end and WAIT exit in the same cycle: wait_sec still increments.

## Timing
- Debounce latency: with the input held low, the strobe appears at the (DEB_MAX+3)th rising edge, counting the first edge that samples low as edge 1. That is 2 cycles of synchroniser plus DEB_MAX counter cycles plus 1 cycle for the strobe register.
- Input lows shorter than DEB_MAX+2 cycles produce no strobe.
- Counter and state updates are registered on the same edge the strobe is high. New values are visible the cycle after the strobe.
- pulse_vld and unit_tick are single-cycle registered strobes, coincident with the count update.
- speed_ppw latches at window end and is then constant for WIN_MAX+1 cycles. A pulse accepted in the window-end cycle is included.

## Configuration
- PULSE_SPEED_EN defined: the speed counter and the speed_ppw register are built.
  - The speed counter counts accepted DRIVE pulses and saturates at 0xFFFF.
  - It is cleared after the window-end latch.
- Undefined: the speed logic is removed and speed_ppw is tied to 0.
- The window timer and wait_sec are always present.

## Test plan
Bench parameters: DEB_MAX=4, WIN_MAX=99, PPU=3, CNT_W=8. Define PULSE_SPEED_EN except in scenario 6.

1. Glitch rejection and debounce latency
   - Stimulus: press stat_key; then, in DRIVE, pulse_port low for 5 cycles, high, then low for 20 cycles.
   - Response: no strobe for the 5-cycle low; one pulse_vld at edge 7 of the 20-cycle low; pulse_num=1.
2. Distance units and state gating
   - Stimulus: 7 valid pulses in DRIVE, then one key press, then 4 pulses.
   - Response: pulse_num=7, dist_units=2 with 2 unit_ticks; drive_stat=1; the 4 pulses are ignored.
3. WAIT timing
   - Stimulus: sit in WAIT for 350 cycles.
   - Response: wait_sec=3 or 4 depending on timer phase, with each increment exactly at a window end.
4. Saturation
   - Stimulus: 260 pulses in DRIVE.
   - Response: pulse_num=255, ovf=1, dist_units=85.
5. Clear and reset priority
   - Stimulus: clr coincident with a pulse strobe; separately, assert sys_rst_n low mid-debounce.
   - Response: clr gives all counters 0, IDLE and no pulse_vld. The reset gives all outputs 0 immediately and no strobe after release.
6. Speed measurement
   - Stimulus: 6 pulses within one window, with one in the window-end cycle.
   - Response: speed_ppw=6. With PULSE_SPEED_EN undefined, speed_ppw=0.

Source files
------------

// File: rtl/wheel_pulse_meter_if.sv
// Signal bundle between the board-facing wheel pulse meter and its users.
// The meter takes the slave view: it receives raw pins and clear, and
// returns trip state, counters and strobes.
interface wheel_pulse_meter_if #(
  parameter int CNT_W = 20
);
  logic             pulse_port;
  logic             stat_key;
  logic             clr;
  logic [1:0]       drive_stat;
  logic [CNT_W-1:0] pulse_num;
  logic [CNT_W-1:0] dist_units;
  logic [15:0]      wait_sec;
  logic [15:0]      speed_ppw;
  logic             pulse_vld;
  logic             unit_tick;
  logic             ovf;

  modport master (
    output pulse_port, stat_key, clr,
    input  drive_stat, pulse_num, dist_units, wait_sec, speed_ppw,
           pulse_vld, unit_tick, ovf
  );

  modport slave (
    input  pulse_port, stat_key, clr,
    output drive_stat, pulse_num, dist_units, wait_sec, speed_ppw,
           pulse_vld, unit_tick, ovf
  );
endinterface

// File: rtl/wheel_pulse_meter.sv
// Wheel pulse front end for the taxi meter: debounces the wheel sensor and
// mode key, runs the IDLE/WAIT/DRIVE trip FSM and accumulates pulses,
// distance units, waiting seconds and windowed speed.
// Optional feature macro: PULSE_SPEED_EN builds the per-window speed counter;
// without it speed_ppw is tied to zero.
module wheel_pulse_meter #(
  parameter int CNT_W   = 20,
  parameter int DEB_MAX = 999_999,
  parameter int WIN_MAX = 49_999_999,
  parameter int PPU     = 10
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  wheel_pulse_meter_if.slave   mtr
);

  localparam int DEB_W = $clog2(DEB_MAX + 1);
  localparam int WIN_W = $clog2(WIN_MAX + 1);
  localparam int SUB_W = (PPU > 1) ? $clog2(PPU) : 1;
  localparam logic [DEB_W-1:0] DEB_TOP = DEB_W'(DEB_MAX);
  localparam logic [WIN_W-1:0] WIN_TOP = WIN_W'(WIN_MAX);
  localparam logic [SUB_W-1:0] SUB_TOP = SUB_W'(PPU - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRIVE = 2'd2
  } state_t;

  // Saturating 16-bit increment used by the wait and speed counters.
  function automatic logic [15:0] inc16_sat(input logic [15:0] v, input logic en);
    return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

  // Channel 0 is the wheel pulse, channel 1 the mode key (both active-low).
  logic [1:0]       raw;
  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       hit_q;
  logic [DEB_W-1:0] deb_cnt_q [2];
  logic [DEB_W-1:0] deb_cnt_d [2];
  logic [1:0]       fire;

  assign raw = {mtr.stat_key, mtr.pulse_port};

  // Debounce counters: clear while the synchronised input is high, count up
  // and hold at DEB_MAX while low. The strobe fires once on the first cycle
  // at DEB_MAX and only if the input is still low one flop earlier, so lows
  // shorter than DEB_MAX+2 cycles never fire.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      deb_cnt_d[i] = deb_cnt_q[i];
      if (sync2_q[i])
        deb_cnt_d[i] = '0;
      else if (deb_cnt_q[i] != DEB_TOP)
        deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
      fire[i] = (deb_cnt_q[i] == DEB_TOP) && !hit_q[i] && !sync1_q[i];
    end
  end

  // Synchronisers, debounce counters and the already-fired flag per channel.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
      hit_q   <= 2'b00;
      for (int i = 0; i < 2; i++) deb_cnt_q[i] <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      for (int i = 0; i < 2; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
        hit_q[i]     <= (deb_cnt_q[i] == DEB_TOP);
      end
    end
  end

  state_t state_q, state_d;

  // Trip FSM next state: clear wins, otherwise the key strobe cycles modes.
  always_comb begin
    state_d = state_q;
    if (mtr.clr) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (fire[1]) state_d = ST_DRIVE;
        ST_DRIVE: if (fire[1]) state_d = ST_WAIT;
        ST_WAIT:  if (fire[1]) state_d = ST_DRIVE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Trip FSM state register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  logic [WIN_W-1:0] win_q, win_d;
  logic             win_end;
  logic             acc;
  logic [CNT_W-1:0] pulse_num_q, pulse_num_d;
  logic [CNT_W-1:0] dist_q, dist_d;
  logic [SUB_W-1:0] sub_q, sub_d;
  logic [15:0]      wait_sec_q, wait_sec_d;
  logic             pulse_vld_q, pulse_vld_d;
  logic             unit_tick_q, unit_tick_d;
  logic             ovf_q, ovf_d;

  assign win_end = (win_q == WIN_TOP);
  assign win_d   = win_end ? '0 : win_q + WIN_W'(1);
  // Pulses count only in DRIVE (pre-transition state) and never beside clr.
  assign acc     = fire[0] && (state_q == ST_DRIVE) && !mtr.clr;

  // Trip counters. Distance follows pulse_num, so pulses arriving after
  // pulse_num saturates only set ovf and do not advance distance.
  always_comb begin
    pulse_num_d = pulse_num_q;
    dist_d      = dist_q;
    sub_d       = sub_q;
    wait_sec_d  = wait_sec_q;
    ovf_d       = ovf_q;
    pulse_vld_d = 1'b0;
    unit_tick_d = 1'b0;
    if (mtr.clr) begin
      pulse_num_d = '0;
      dist_d      = '0;
      sub_d       = '0;
      wait_sec_d  = '0;
      ovf_d       = 1'b0;
    end else begin
      if (acc) begin
        pulse_vld_d = 1'b1;
        if (pulse_num_q == '1) begin
          ovf_d = 1'b1;
        end else begin
          pulse_num_d = pulse_num_q + CNT_W'(1);
          if (sub_q == SUB_TOP) begin
            sub_d       = '0;
            unit_tick_d = 1'b1;
            if (dist_q == '1) ovf_d = 1'b1;
            else              dist_d = dist_q + CNT_W'(1);
          end else begin
            sub_d = sub_q + SUB_W'(1);
          end
        end
      end
      wait_sec_d = inc16_sat(wait_sec_q, win_end && (state_q == ST_WAIT));
    end
  end

  // Window timer and trip counter registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      win_q       <= '0;
      pulse_num_q <= '0;
      dist_q      <= '0;
      sub_q       <= '0;
      wait_sec_q  <= '0;
      ovf_q       <= 1'b0;
      pulse_vld_q <= 1'b0;
      unit_tick_q <= 1'b0;
    end else begin
      win_q       <= win_d;
      pulse_num_q <= pulse_num_d;
      dist_q      <= dist_d;
      sub_q       <= sub_d;
      wait_sec_q  <= wait_sec_d;
      ovf_q       <= ovf_d;
      pulse_vld_q <= pulse_vld_d;
      unit_tick_q <= unit_tick_d;
    end
  end

`ifdef PULSE_SPEED_EN
  logic [15:0] spd_cnt_q, spd_cnt_d;
  logic [15:0] speed_q, speed_d;

  // Speed: latch this window's count (including a window-end pulse), restart.
  always_comb begin
    spd_cnt_d = inc16_sat(spd_cnt_q, acc);
    speed_d   = speed_q;
    if (win_end) begin
      speed_d   = spd_cnt_d;
      spd_cnt_d = '0;
    end
  end

  // Speed counter and latched speed registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      spd_cnt_q <= '0;
      speed_q   <= '0;
    end else begin
      spd_cnt_q <= spd_cnt_d;
      speed_q   <= speed_d;
    end
  end

  assign mtr.speed_ppw = speed_q;
`else
  assign mtr.speed_ppw = '0;
`endif

  assign mtr.drive_stat = state_q;
  assign mtr.pulse_num  = pulse_num_q;
  assign mtr.dist_units = dist_q;
  assign mtr.wait_sec   = wait_sec_q;
  assign mtr.pulse_vld  = pulse_vld_q;
  assign mtr.unit_tick  = unit_tick_q;
  assign mtr.ovf        = ovf_q;

endmodule

// File: tb/tb_wheel_pulse_meter.sv
// Directed bench for wheel_pulse_meter with DEB_MAX=4, WIN_MAX=99, PPU=3,
// CNT_W=8. Expected values are hand-derived; a tiny shadow of trip state and
// waiting seconds tracks window ends by counting clock edges since reset.
module tb_wheel_pulse_meter;

  localparam int WIN = 100;
`ifdef PULSE_SPEED_EN
  localparam int SPD_EXP = 6;
`else
  localparam int SPD_EXP = 0;
`endif

  logic clk;
  logic rst_n;

  wheel_pulse_meter_if #(.CNT_W(8)) bus ();

  wheel_pulse_meter #(
    .CNT_W   (8),
    .DEB_MAX (4),
    .WIN_MAX (99),
    .PPU     (3)
  ) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .mtr       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int ecnt   = 0;
  int vld_cnt  = 0;
  int tick_cnt = 0;
  int m_state  = 0;
  int m_ws     = 0;
  int base_v, base_t;

  // Edges since reset release; edge n with n%100==0 is a window end.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ecnt <= 0;
    else        ecnt <= ecnt + 1;
  end

  always @(negedge clk) begin
    if (bus.pulse_vld) vld_cnt  <= vld_cnt + 1;
    if (bus.unit_tick) tick_cnt <= tick_cnt + 1;
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rst_n && m_state == 1 && (ecnt % WIN) == 0) m_ws++;
  endtask

  task automatic press_pulse();
    bus.pulse_port = 1'b0;
    repeat (7) tick();
    bus.pulse_port = 1'b1;
    repeat (4) tick();
  endtask

  task automatic press_key();
    bus.stat_key = 1'b0;
    repeat (7) tick();
    case (m_state)
      0: m_state = 2;
      2: m_state = 1;
      default: m_state = 2;
    endcase
    bus.stat_key = 1'b1;
    repeat (4) tick();
  endtask

  task automatic do_clr();
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    m_state = 0;
    m_ws    = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_stat"}, int'(bus.drive_stat), 0);
    check_eq({tag, "_pnum"}, int'(bus.pulse_num), 0);
    check_eq({tag, "_dist"}, int'(bus.dist_units), 0);
    check_eq({tag, "_wait"}, int'(bus.wait_sec), 0);
    check_eq({tag, "_ovf"},  int'(bus.ovf), 0);
    check_eq({tag, "_vld"},  int'(bus.pulse_vld), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    bus.pulse_port = 1'b1;
    bus.stat_key   = 1'b1;
    bus.clr        = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("rst");
    check_eq("rst_speed", int'(bus.speed_ppw), 0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    // 1: glitch rejection and debounce latency
    press_key();
    check_eq("s1_drive", int'(bus.drive_stat), 2);
    base_v = vld_cnt;
    bus.pulse_port = 1'b0;
    repeat (5) tick();
    bus.pulse_port = 1'b1;
    repeat (6) tick();
    check_eq("s1_glitch", vld_cnt - base_v, 0);
    bus.pulse_port = 1'b0;
    repeat (6) tick();
    check_eq("s1_edge6", int'(bus.pulse_vld), 0);
    tick();
    check_eq("s1_edge7", int'(bus.pulse_vld), 1);
    check_eq("s1_pnum", int'(bus.pulse_num), 1);
    tick();
    check_eq("s1_edge8", int'(bus.pulse_vld), 0);
    repeat (12) tick();
    bus.pulse_port = 1'b1;
    repeat (4) tick();
    check_eq("s1_once", vld_cnt - base_v, 1);
    check_eq("s1_pnum_end", int'(bus.pulse_num), 1);

    // 2: distance units and state gating
    do_clr();
    check_all_zero("clr0");
    press_key();
    base_t = tick_cnt;
    repeat (7) press_pulse();
    check_eq("s2_pnum", int'(bus.pulse_num), 7);
    check_eq("s2_dist", int'(bus.dist_units), 2);
    check_eq("s2_ticks", tick_cnt - base_t, 2);
    press_key();
    check_eq("s2_wait", int'(bus.drive_stat), 1);
    base_v = vld_cnt;
    repeat (4) press_pulse();
    check_eq("s2_drop_vld", vld_cnt - base_v, 0);
    check_eq("s2_drop_pnum", int'(bus.pulse_num), 7);
    check_eq("s2_drop_dist", int'(bus.dist_units), 2);

    // 3: waiting seconds increment exactly at window ends
    do_clr();
    press_key();
    press_key();
    check_eq("s3_wait", int'(bus.drive_stat), 1);
    for (int i = 0; i < 350; i++) begin
      tick();
      check_eq("s3_wait_sec", int'(bus.wait_sec), m_ws);
    end
    check_eq("s3_range", int'(m_ws == 3 || m_ws == 4), 1);

    // 4: saturation
    do_clr();
    press_key();
    repeat (255) press_pulse();
    check_eq("s4_pnum255", int'(bus.pulse_num), 255);
    check_eq("s4_dist85", int'(bus.dist_units), 85);
    check_eq("s4_ovf_pre", int'(bus.ovf), 0);
    repeat (5) press_pulse();
    check_eq("s4_pnum_sat", int'(bus.pulse_num), 255);
    check_eq("s4_dist_sat", int'(bus.dist_units), 85);
    check_eq("s4_ovf", int'(bus.ovf), 1);

    // 5a: clr coincident with a pulse strobe
    bus.pulse_port = 1'b0;
    repeat (6) tick();
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    m_state = 0;
    m_ws = 0;
    check_all_zero("s5_clr");
    bus.pulse_port = 1'b1;
    repeat (4) tick();

    // 5b: asynchronous reset in the middle of a debounce
    press_key();
    press_pulse();
    check_eq("s5_pre_pnum", int'(bus.pulse_num), 1);
    bus.pulse_port = 1'b0;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("s5_rst");
    bus.pulse_port = 1'b1;
    m_state = 0;
    m_ws = 0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    base_v = vld_cnt;
    repeat (15) tick();
    check_eq("s5_no_strobe", vld_cnt - base_v, 0);
    check_eq("s5_idle", int'(bus.drive_stat), 0);

    // 6: speed over one window with a pulse in the window-end cycle
    do_clr();
    press_key();
    while ((ecnt % WIN) != 1) tick();
    repeat (5) press_pulse();
    while ((ecnt % WIN) != 93) tick();
    bus.pulse_port = 1'b0;
    repeat (7) tick();
    check_eq("s6_end_vld", int'(bus.pulse_vld), 1);
    check_eq("s6_speed", int'(bus.speed_ppw), SPD_EXP);
    bus.pulse_port = 1'b1;
    repeat (50) tick();
    check_eq("s6_speed_hold", int'(bus.speed_ppw), SPD_EXP);
    while ((ecnt % WIN) != 0) tick();
    check_eq("s6_speed_next", int'(bus.speed_ppw), 0);
    check_eq("s6_pnum", int'(bus.pulse_num), 6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
